// File: rtl/i2c_target.sv
// i2c_target: I2C target with a 16-byte buffer shared by receive and transmit, plus a CPU register map.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample level filter behind the SCL/SDA synchronizers.
module i2c_target #(
  parameter logic [15:0] DEVICE_ID      = 16'h0,
  parameter logic [7:0]  DEVICE_TYPE    = 8'hA,
  parameter logic [6:0]  TARGET_ADDRESS = 7'h42
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        is_control,
  input  logic [7:0]  short_address,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_out,
  output logic        SDA_enable
);
  localparam int unsigned BUF_BYTES = 16;
  localparam int unsigned PTR_W     = 5;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        scl_sync, sda_sync;
  logic              scl_lvl, sda_lvl, scl_prev, sda_prev;
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        shift_q, rx_byte, tx_byte;
  logic [2:0]        bit_cnt;
  logic              ack_phase, ack_ok, sda_en_d;
  logic [PTR_W-1:0]  ptr_q, rx_count;
  logic              overflow, read_done, busy;
  logic [6:0]        own_addr, addr_active;
  logic [7:0]        buffer [BUF_BYTES];
  logic [2:0]        cpu_word;
  logic              cpu_is_buf;
  logic              unused_addr_bits;

  // Two-flop synchronizers, idle-high
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], SCL_in};
      sda_sync <= {sda_sync[0], SDA_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  // A level is accepted only once three consecutive samples agree
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_lvl  <= 1'b1;
      sda_lvl  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      if (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) scl_lvl <= scl_sync[1];
      if (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) sda_lvl <= sda_sync[1];
    end
  end
`else
  assign scl_lvl = scl_sync[1];
  assign sda_lvl = sda_sync[1];
`endif

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_lvl;
      sda_prev <= sda_lvl;
    end
  end

  assign scl_rise   = scl_lvl & ~scl_prev;
  assign scl_fall   = ~scl_lvl & scl_prev;
  assign start_det  = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
  assign stop_det   = scl_lvl & scl_prev & ~sda_prev & sda_lvl;
  assign rx_byte    = {shift_q[6:0], sda_lvl};
  assign tx_byte    = buffer[ptr_q[3:0]];
  assign busy       = (state_q != IDLE);
  assign cpu_word   = 3'(short_address[3:0] - 4'd4);
  assign cpu_is_buf = (short_address[3:2] == 2'b01) || (short_address[3:2] == 2'b10);
  assign unused_addr_bits = ^short_address[7:4];

  // State register and registered bus outputs
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      SDA_enable <= 1'b0;
      SDA_out    <= 1'b0;
    end else begin
      state_q    <= state_d;
      SDA_enable <= sda_en_d;
      SDA_out    <= 1'b0;
    end
  end

  // Next-state logic; START and STOP override every state
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (scl_rise && bit_cnt == 3'd7)
                    state_d = (rx_byte[7:1] == addr_active) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && ack_phase) state_d = shift_q[0] ? TX_BYTE : RX_BYTE;
        RX_BYTE:  if (scl_rise && bit_cnt == 3'd7) state_d = RX_ACK;
        RX_ACK:   if (scl_fall && ack_phase) state_d = RX_BYTE;
        TX_BYTE:  if (scl_fall && bit_cnt == 3'd7) state_d = TX_ACK;
        TX_ACK: begin
          if (scl_rise && sda_lvl) state_d = IGNORE;
          else if (scl_fall && ack_phase) state_d = TX_BYTE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // SDA drive decision; only SCL falling may assert or release it (START/STOP release)
  always_comb begin
    sda_en_d = SDA_enable;
    if (start_det || stop_det) begin
      sda_en_d = 1'b0;
    end else if (scl_fall) begin
      case (state_q)
        ADDR_ACK: sda_en_d = !ack_phase ? 1'b1 : (shift_q[0] & ~tx_byte[7]);
        RX_ACK:   sda_en_d = !ack_phase & ack_ok;
        TX_BYTE:  sda_en_d = (bit_cnt == 3'd7) ? 1'b0 : ~shift_q[6];
        TX_ACK:   sda_en_d = ack_phase & ~tx_byte[7];
        default:  sda_en_d = 1'b0;
      endcase
    end
  end

  // Datapath: CPU writes first so a same-cycle bus store to the same byte wins.
  // ack_phase: in *_ACK of address/rx it marks the drive half; in TX_ACK it marks an ACK received.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      ack_phase   <= 1'b0;
      ack_ok      <= 1'b0;
      ptr_q       <= '0;
      rx_count    <= '0;
      overflow    <= 1'b0;
      read_done   <= 1'b0;
      own_addr    <= TARGET_ADDRESS;
      addr_active <= TARGET_ADDRESS;
      buffer      <= '{default: '0};
    end else begin
      if (write_enable && is_control) begin
        if (short_address[3:0] == 4'd2) own_addr <= cpu_data_in[6:0];
        if (short_address[3:0] == 4'd3) begin
          rx_count  <= '0;
          overflow  <= 1'b0;
          read_done <= 1'b0;
        end
        if (cpu_is_buf) begin
          buffer[{cpu_word, 1'b0}] <= cpu_data_in[7:0];
          buffer[{cpu_word, 1'b1}] <= cpu_data_in[15:8];
        end
      end
      if (start_det) begin
        ptr_q       <= '0;
        bit_cnt     <= '0;
        ack_phase   <= 1'b0;
        addr_active <= own_addr;
      end else if (stop_det) begin
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        case (state_q)
          ADDR, RX_BYTE: if (scl_rise) begin
            shift_q <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (state_q == RX_BYTE && bit_cnt == 3'd7) begin
              if (ptr_q < PTR_W'(BUF_BYTES)) begin
                buffer[ptr_q[3:0]] <= rx_byte;
                ptr_q    <= ptr_q + PTR_W'(1);
                rx_count <= ptr_q + PTR_W'(1);
                ack_ok   <= 1'b1;
              end else begin
                overflow <= 1'b1;
                ack_ok   <= 1'b0;
              end
            end
          end
          ADDR_ACK, RX_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (state_q == ADDR_ACK && shift_q[0]) shift_q <= tx_byte;
            end
          end
          TX_BYTE: if (scl_fall) begin
            shift_q <= {shift_q[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_lvl) begin
                ack_phase <= 1'b1;
                ptr_q     <= {1'b0, ptr_q[3:0] + 4'd1};
              end else begin
                read_done <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              shift_q   <= tx_byte;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Zero-latency register read mux
  always_comb begin
    cpu_data_out = 16'h0;
    if (is_control) begin
      case (short_address[3:0])
        4'd0: cpu_data_out = DEVICE_ID;
        4'd1: cpu_data_out = {8'h0, DEVICE_TYPE};
        4'd2: cpu_data_out = {9'h0, own_addr};
        4'd3: cpu_data_out = {5'h0, read_done, overflow, busy, 3'h0, rx_count};
        default:
          if (cpu_is_buf) cpu_data_out = {buffer[{cpu_word, 1'b1}], buffer[{cpu_word, 1'b0}]};
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: open-drain initiator model plus CPU port driver; register table and bus scoreboard.
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int Q  = 8;
  localparam int NV = 14;

  logic        cpu_clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic        is_control = 1'b0;
  logic [7:0]  short_address = 8'h0;
  logic [15:0] cpu_data_in = 16'h0;
  logic [15:0] cpu_data_out;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        SDA_out, SDA_enable;

  typedef struct {
    logic        we;
    logic        ctl;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] val;
    logic       is_ack;
  } exp_t;

  vec_t vec [NV];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   drive_cycles = 0;

  assign sda_bus = sda_m & ~SDA_enable;

  i2c_target dut (
    .cpu_clock    (cpu_clock),
    .reset        (reset),
    .write_enable (write_enable),
    .is_control   (is_control),
    .short_address(short_address),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .SCL_in       (scl),
    .SDA_in       (sda_bus),
    .SDA_out      (SDA_out),
    .SDA_enable   (SDA_enable)
  );

  always #5 cpu_clock = ~cpu_clock;

  always @(posedge cpu_clock) if (SDA_enable) drive_cycles++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name, input logic [7:0] act, input logic is_ack);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: nothing expected, got %h", name, act);
    end else begin
      e = sb_q.pop_front();
      check(name, {7'h0, is_ack, act}, {7'h0, e.is_ack, e.val});
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge cpu_clock);
  endtask

  task automatic do_reset();
    @(negedge cpu_clock) reset = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(1);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge cpu_clock);
    is_control = 1'b1; write_enable = 1'b1; short_address = a; cpu_data_in = d;
    @(negedge cpu_clock);
    write_enable = 1'b0;
  endtask

  task automatic cpu_read(input logic ctl, input logic [7:0] a, output logic [15:0] d);
    @(negedge cpu_clock);
    is_control = ctl; short_address = a;
    #1 d = cpu_data_out;
    is_control = 1'b1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hold(Q);
    scl = 1'b1;   hold(Q);
    sda_m = 1'b0; hold(Q);
    scl = 1'b0;   hold(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hold(Q);
    scl = 1'b1;   hold(Q);
    sda_m = 1'b1; hold(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; hold(Q);
      scl = 1'b1;   hold(2 * Q);
      scl = 1'b0;   hold(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    logic ack;
    sb_q.push_back('{val: {7'h0, exp_ack}, is_ack: 1'b1});
    send_bits(b);
    sda_m = 1'b1; hold(Q);
    scl = 1'b1;   hold(Q);
    ack = ~sda_bus;
    hold(Q);
    scl = 1'b0;   hold(Q);
    sb_compare($sformatf("ack_%02h", b), {7'h0, ack}, 1'b1);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic send_ack);
    logic [7:0] b;
    sb_q.push_back('{val: exp, is_ack: 1'b0});
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hold(Q);
      scl = 1'b1; hold(Q);
      b[i] = sda_bus;
      hold(Q);
      scl = 1'b0;
    end
    hold(Q);
    sda_m = ~send_ack; hold(Q);
    scl = 1'b1;        hold(2 * Q);
    scl = 1'b0;        hold(Q);
    sda_m = 1'b1;
    sb_compare("rd_byte", b, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    int snap;

    // {we, ctl, addr, wdata, expected read}
    vec[0]  = '{1'b0, 1'b1, 8'h00, 16'h0000, 16'h0000};
    vec[1]  = '{1'b0, 1'b1, 8'h01, 16'h0000, 16'h000A};
    vec[2]  = '{1'b0, 1'b1, 8'h02, 16'h0000, 16'h0042};
    vec[3]  = '{1'b0, 1'b1, 8'h03, 16'h0000, 16'h0000};
    vec[4]  = '{1'b0, 1'b1, 8'h04, 16'h0000, 16'h0000};
    vec[5]  = '{1'b0, 1'b0, 8'h01, 16'h0000, 16'h0000};
    vec[6]  = '{1'b1, 1'b1, 8'h05, 16'hBEEF, 16'hBEEF};
    vec[7]  = '{1'b1, 1'b1, 8'h0C, 16'hFFFF, 16'h0000};
    vec[8]  = '{1'b0, 1'b1, 8'h15, 16'h0000, 16'hBEEF};
    vec[9]  = '{1'b1, 1'b1, 8'h02, 16'hFFFF, 16'h007F};
    vec[10] = '{1'b1, 1'b1, 8'h02, 16'h0042, 16'h0042};
    vec[11] = '{1'b1, 1'b1, 8'h00, 16'h1234, 16'h0000};
    vec[12] = '{1'b1, 1'b1, 8'h0B, 16'hA55A, 16'hA55A};
    vec[13] = '{1'b1, 1'b1, 8'h03, 16'hFFFF, 16'h0000};

    hold(4);
    check("reset_sda_enable", {15'h0, SDA_enable}, 16'h0);
    check("reset_sda_out", {15'h0, SDA_out}, 16'h0);
    reset = 1'b0;
    hold(2);

    for (int i = 0; i < NV; i++) begin
      if (vec[i].we) cpu_write(vec[i].addr, vec[i].wdata);
      cpu_read(vec[i].ctl, vec[i].addr, d);
      check($sformatf("reg_vec%0d", i), d, vec[i].exp);
    end

    // Three-byte write to own address
    do_reset();
    i2c_start();
    write_byte(8'h84, 1'b1);
    write_byte(8'hA5, 1'b1);
    write_byte(8'h3C, 1'b1);
    i2c_stop();
    cpu_read(1'b1, 8'h03, d); check("wr3_status", d, 16'h0002);
    cpu_read(1'b1, 8'h04, d); check("wr3_word4", d, 16'h3CA5);

    // Foreign address: never drive SDA
    cpu_write(8'h03, 16'h0);
    snap = drive_cycles;
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h12, 1'b0);
    write_byte(8'h34, 1'b0);
    i2c_stop();
    check("foreign_drive_cycles", 16'(drive_cycles - snap), 16'h0);
    cpu_read(1'b1, 8'h03, d); check("foreign_status", d, 16'h0000);

    // Read two bytes, ACK then NACK
    cpu_write(8'h04, 16'h1234);
    cpu_write(8'h03, 16'h0);
    i2c_start();
    write_byte(8'h85, 1'b1);
    read_byte(8'h34, 1'b1);
    read_byte(8'h12, 1'b0);
    i2c_stop();
    cpu_read(1'b1, 8'h03, d); check("read_status", d, 16'h0400);

    // Seventeen bytes: last one overflows
    do_reset();
    i2c_start();
    write_byte(8'h84, 1'b1);
    for (int i = 1; i <= 17; i++) write_byte(8'(i), i <= 16);
    i2c_stop();
    cpu_read(1'b1, 8'h03, d); check("ovf_status", d, 16'h0210);
    cpu_read(1'b1, 8'h04, d); check("ovf_word4", d, 16'h0201);
    cpu_read(1'b1, 8'h0B, d); check("ovf_word11", d, 16'h100F);

    // Write, repeated START, read back
    do_reset();
    i2c_start();
    write_byte(8'h84, 1'b1);
    write_byte(8'h11, 1'b1);
    i2c_start();
    cpu_read(1'b1, 8'h03, d); check("rs_busy_after_rstart", d, 16'h0101);
    write_byte(8'h85, 1'b1);
    read_byte(8'h11, 1'b0);
    cpu_read(1'b1, 8'h03, d); check("rs_busy_before_stop", d, 16'h0501);
    i2c_stop();
    cpu_read(1'b1, 8'h03, d); check("rs_after_stop", d, 16'h0401);

    // Reset while the target is driving a data ACK
    do_reset();
    i2c_start();
    write_byte(8'h84, 1'b1);
    send_bits(8'h5A);
    sda_m = 1'b1;
    check("rxack_driving", {15'h0, SDA_enable}, 16'h0001);
    @(negedge cpu_clock) reset = 1'b1;
    @(negedge cpu_clock);
    check("rxack_reset_release", {15'h0, SDA_enable}, 16'h0);
    is_control = 1'b1; short_address = 8'h03;
    #1 check("rxack_reset_status", cpu_data_out, 16'h0000);
    reset = 1'b0;
    scl = 1'b1; hold(2 * Q);
    scl = 1'b0; hold(Q);
    snap = drive_cycles;
    send_bits(8'h84);
    scl = 1'b1; hold(2 * Q);
    scl = 1'b0; hold(Q);
    check("post_reset_ignored", 16'(drive_cycles - snap), 16'h0);
    i2c_stop();
    cpu_read(1'b1, 8'h03, d); check("post_reset_status", d, 16'h0000);

    check("scoreboard_empty", 16'(sb_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
